game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 155 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Endless-runner game state controller: IDLE/RUN/DEAD sequencing, score,
// high score, scroll-speed ramp and scene restart pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE 00 | waiting for first jump edge, scene frozen
// RUN  01 | scrolling, score counting, collision ends the run
// DEAD 10 | scene frozen, hold timer must expire before a restart
module game_state_ctrl #(
  parameter int DX_INIT   = 4,
  parameter int DX_MAX    = 16,
  parameter int SCORE_DIV = 6,
  parameter int RAMP_PTS  = 100,
  parameter int DEAD_HOLD = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frameTick,
  input  logic        jumpBtn,
  input  logic        collision,
  output logic [1:0]  gameState,
  output logic [5:0]  scrollDx,
  output logic [13:0] score,
  output logic [13:0] hiScore,
  output logic        restart
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  localparam int FW = $clog2(SCORE_DIV + 1);
  localparam int RW = $clog2(RAMP_PTS + 1);
  localparam int HW = $clog2(DEAD_HOLD + 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [13:0]   score_q, score_d;
  logic [13:0]   hi_q, hi_d;
  logic [5:0]    dx_q, dx_d;
  logic          restart_q, restart_d;
  logic          btn_prev;
  logic          jump_edge;

  // Button history resets high so a button held through reset is not an edge.
  assign jump_edge = jumpBtn & ~btn_prev;

  // State and all output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      ramp_q    <= '0;
      hold_q    <= '0;
      score_q   <= '0;
      hi_q      <= '0;
      dx_q      <= '0;
      restart_q <= 1'b0;
      btn_prev  <= 1'b1;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      ramp_q    <= ramp_d;
      hold_q    <= hold_d;
      score_q   <= score_d;
      hi_q      <= hi_d;
      dx_q      <= dx_d;
      restart_q <= restart_d;
      btn_prev  <= jumpBtn;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    ramp_d    = ramp_q;
    hold_d    = hold_q;
    score_d   = score_q;
    hi_d      = hi_q;
    dx_d      = dx_q;
    restart_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dx_d = '0;
        if (jump_edge) begin
          state_d   = ST_RUN;
          score_d   = '0;
          frame_d   = '0;
          ramp_d    = '0;
          dx_d      = 6'(DX_INIT);
          restart_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (collision) begin
          state_d = ST_DEAD;
          dx_d    = '0;
          hold_d  = '0;
          if (score_q > hi_q) hi_d = score_q;
        end else if (frameTick) begin
          if (frame_q == FW'(SCORE_DIV - 1)) begin
            frame_d = '0;
            // Ramp counter tracks points since the last speed step, avoiding a
            // modulo of the score itself.
            if (score_q < SCORE_MAX) begin
              score_d = score_q + 14'd1;
              if (ramp_q == RW'(RAMP_PTS - 1)) begin
                ramp_d = '0;
                if (dx_q < 6'(DX_MAX)) dx_d = dx_q + 6'd1;
              end else begin
                ramp_d = ramp_q + RW'(1);
              end
            end
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end

      ST_DEAD: begin
        dx_d = '0;
        if (jump_edge && hold_q == HW'(DEAD_HOLD)) begin
          state_d   = ST_RUN;
          score_d   = '0;
          frame_d   = '0;
          ramp_d    = '0;
          dx_d      = 6'(DX_INIT);
          restart_d = 1'b1;
        end else if (frameTick && hold_q < HW'(DEAD_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        dx_d    = '0;
      end
    endcase
  end

  assign gameState = state_q;
  assign scrollDx  = dx_q;
  assign score     = score_q;
  assign hiScore   = hi_q;
  assign restart   = restart_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: stimulus queues hand-computed
// expectations tagged with a cycle number, a monitor pops and compares them.
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frameTick, jumpBtn, collision;
  logic [1:0]  gameState;
  logic [5:0]  scrollDx;
  logic [13:0] score, hiScore;
  logic        restart;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic [1:0]  st;
    logic [5:0]  dx;
    logic [13:0] sc;
    logic [13:0] hi;
    logic        rs;
  } exp_t;

  exp_t q[$];

  game_state_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frameTick (frameTick),
    .jumpBtn   (jumpBtn),
    .collision (collision),
    .gameState (gameState),
    .scrollDx  (scrollDx),
    .score     (score),
    .hiScore   (hiScore),
    .restart   (restart)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle, flag any left stale.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || gameState !== e.st || scrollDx !== e.dx ||
          score !== e.sc || hiScore !== e.hi || restart !== e.rs) begin
        failures++;
        $display("FAIL %s cyc=%0d got st=%0d dx=%0d sc=%0d hi=%0d rs=%0d exp st=%0d dx=%0d sc=%0d hi=%0d rs=%0d",
                 e.name, cyc, gameState, scrollDx, score, hiScore, restart,
                 e.st, e.dx, e.sc, e.hi, e.rs);
      end
    end
  end

  task automatic tick(input logic jb, input logic col, input logic ft);
    jumpBtn   = jb;
    collision = col;
    frameTick = ft;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [1:0] st, input logic [5:0] dx,
                            input logic [13:0] sc, input logic [13:0] hi, input logic rs);
    exp_t e;
    e.name = n; e.cyc = cyc; e.st = st; e.dx = dx; e.sc = sc; e.hi = hi; e.rs = rs;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; jumpBtn = 1'b0; collision = 1'b0; frameTick = 1'b0;
    tick(0, 0, 0);
    tick(0, 0, 0);
    expect_out("reset", 2'd0, 6'd0, 14'd0, 14'd0, 1'b0);

    // Button held through reset release must not start a game.
    tick(1, 0, 0);
    rst_n = 1'b1;
    tick(1, 0, 0);
    tick(1, 0, 0);
    expect_out("held_btn_idle", 2'd0, 6'd0, 14'd0, 14'd0, 1'b0);
    tick(1, 1, 1);
    expect_out("idle_ignores", 2'd0, 6'd0, 14'd0, 14'd0, 1'b0);

    tick(0, 0, 0);
    tick(1, 0, 0);
    expect_out("start", 2'd1, 6'd4, 14'd0, 14'd0, 1'b1);
    tick(1, 0, 0);
    expect_out("restart_one_cycle", 2'd1, 6'd4, 14'd0, 14'd0, 1'b0);

    for (int i = 0; i < 5; i++) tick(1, 0, 1);
    expect_out("five_ticks", 2'd1, 6'd4, 14'd0, 14'd0, 1'b0);
    tick(1, 0, 1);
    expect_out("first_point", 2'd1, 6'd4, 14'd1, 14'd0, 1'b0);

    tick(0, 0, 0);
    tick(1, 0, 0);
    expect_out("run_jump_ignored", 2'd1, 6'd4, 14'd1, 14'd0, 1'b0);

    for (int i = 0; i < 216; i++) tick(0, 0, 1);
    expect_out("score37", 2'd1, 6'd4, 14'd37, 14'd0, 1'b0);
    tick(0, 1, 1);
    expect_out("collide_37", 2'd2, 6'd0, 14'd37, 14'd37, 1'b0);

    for (int i = 0; i < 29; i++) tick(0, 0, 1);
    tick(1, 0, 0);
    expect_out("dead_early_jump", 2'd2, 6'd0, 14'd37, 14'd37, 1'b0);
    tick(0, 0, 1);
    tick(1, 0, 0);
    expect_out("dead_restart", 2'd1, 6'd4, 14'd0, 14'd37, 1'b1);
    tick(1, 0, 0);
    expect_out("dead_restart_end", 2'd1, 6'd4, 14'd0, 14'd37, 1'b0);

    for (int i = 0; i < 120; i++) tick(0, 0, 1);
    tick(0, 1, 0);
    expect_out("die20_hi_kept", 2'd2, 6'd0, 14'd20, 14'd37, 1'b0);

    for (int i = 0; i < 30; i++) tick(0, 0, 1);
    tick(1, 0, 0);
    expect_out("run3_start", 2'd1, 6'd4, 14'd0, 14'd37, 1'b1);

    for (int i = 1; i <= 60000; i++) begin
      tick(0, 0, 1);
      if (i == 594)   expect_out("score99",   2'd1, 6'd4,  14'd99,   14'd37, 1'b0);
      if (i == 600)   expect_out("score100",  2'd1, 6'd5,  14'd100,  14'd37, 1'b0);
      if (i == 6600)  expect_out("score1100", 2'd1, 6'd15, 14'd1100, 14'd37, 1'b0);
      if (i == 7200)  expect_out("score1200", 2'd1, 6'd16, 14'd1200, 14'd37, 1'b0);
      if (i == 7800)  expect_out("score1300", 2'd1, 6'd16, 14'd1300, 14'd37, 1'b0);
      if (i == 59994) expect_out("score9999", 2'd1, 6'd16, 14'd9999, 14'd37, 1'b0);
      if (i == 60000) expect_out("score_sat", 2'd1, 6'd16, 14'd9999, 14'd37, 1'b0);
    end
    tick(0, 1, 0);
    expect_out("die_max", 2'd2, 6'd0, 14'd9999, 14'd9999, 1'b0);

    // Reset with a simultaneous jump edge, collision and frame tick.
    rst_n = 1'b0;
    tick(1, 1, 1);
    expect_out("reset_priority", 2'd0, 6'd0, 14'd0, 14'd0, 1'b0);
    rst_n = 1'b1;
    tick(1, 0, 0);
    expect_out("post_reset_held", 2'd0, 6'd0, 14'd0, 14'd0, 1'b0);

    tick(0, 0, 0);
    tick(0, 0, 0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
